// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the program counter, drives the
// combinational instruction ROM and registers the returned word for decode.
// Redirects squash the single wrong-path word already in flight, so a taken
// branch costs exactly one bubble.
module fetch_unit #(
    parameter int IW         = 10,
    parameter int DW         = 9,
    parameter int START_ADDR = 0,
    parameter int CW         = 16
) (
    input  logic          CLK,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic          Stall,
    input  logic          BranchTaken,
    input  logic          BranchAbs,
    input  logic [IW-1:0] BranchTarget,
    input  logic          Halt,
    output logic [IW-1:0] InstAddress,
    input  logic [DW-1:0] InstIn,
    output logic [DW-1:0] InstReg,
    output logic [IW-1:0] InstPC,
    output logic          InstValid,
    output logic          Done,
    output logic [CW-1:0] CycleCount
);

    localparam logic [IW-1:0] START_PC = IW'(START_ADDR);
    localparam logic [CW-1:0] CC_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    // Word handed to the decoder together with its fetch address.
    typedef struct packed {
        logic [IW-1:0] pc;
        logic [DW-1:0] word;
        logic          valid;
    } fetch_t;

    state_t        state, state_nxt;
    logic [IW-1:0] pc, pc_nxt;
    logic [IW-1:0] br_target;
    fetch_t        ir, ir_nxt;
    logic          done, done_nxt;
    logic [CW-1:0] cc, cc_nxt;

    // Redirect target; relative offsets are taken from the branch's own PC
    // and wrap naturally in IW bits.
    always_comb begin
        br_target = BranchAbs ? BranchTarget : (ir.pc + BranchTarget);
    end

    // Next-state and datapath: Stall > Halt > BranchTaken > sequential fetch.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        done_nxt  = done;
        cc_nxt    = cc;
        case (state)
            IDLE: begin
                ir_nxt.valid = 1'b0;
                if (Start) begin
                    state_nxt = RUN;
                    pc_nxt    = START_PC;
                    cc_nxt    = '0;
                end
            end
            RUN: begin
                if (cc != CC_MAX) cc_nxt = cc + CW'(1);
                // Under stall the decoder keeps Halt/Branch asserted, so
                // nothing is sampled until the stall drops.
                if (!Stall) begin
                    if (Halt && ir.valid) begin
                        state_nxt    = HALTED;
                        ir_nxt.valid = 1'b0;
                        done_nxt     = 1'b1;
                    end else if (BranchTaken && ir.valid) begin
                        pc_nxt       = br_target;
                        ir_nxt.valid = 1'b0;
                    end else begin
                        ir_nxt.word  = InstIn;
                        ir_nxt.pc    = pc;
                        ir_nxt.valid = 1'b1;
                        pc_nxt       = pc + IW'(1);
                    end
                end
            end
            HALTED: begin
                ir_nxt.valid = 1'b0;
                done_nxt     = 1'b1;
                if (Start) begin
                    state_nxt = RUN;
                    pc_nxt    = START_PC;
                    cc_nxt    = '0;
                    done_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                ir_nxt.valid = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset is asynchronous and immediate.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            pc    <= START_PC;
            ir    <= '0;
            done  <= 1'b0;
            cc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
            done  <= done_nxt;
            cc    <= cc_nxt;
        end
    end

    assign InstAddress = pc;
    assign InstReg     = ir.word;
    assign InstPC      = ir.pc;
    assign InstValid   = ir.valid;
    assign Done        = done;
    assign CycleCount  = cc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan sequences followed by randomized stimulus.
// A behavioural model predicts every cycle; predicted decoder words go into a
// queue that an independent monitor drains whenever the DUT shows InstValid.
module tb_fetch_unit;

    localparam int IW = 10;
    localparam int DW = 9;
    localparam int CW = 6;   // narrow counter so saturation is reachable
    localparam logic [CW-1:0] CC_MAX = '1;

    logic          CLK = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Start = 1'b0;
    logic          Stall = 1'b0;
    logic          BranchTaken = 1'b0;
    logic          BranchAbs = 1'b0;
    logic [IW-1:0] BranchTarget = '0;
    logic          Halt = 1'b0;
    logic [IW-1:0] InstAddress;
    logic [DW-1:0] InstIn;
    logic [DW-1:0] InstReg;
    logic [IW-1:0] InstPC;
    logic          InstValid;
    logic          Done;
    logic [CW-1:0] CycleCount;

    logic [DW-1:0] rom [0:(1<<IW)-1];
    assign InstIn = rom[InstAddress];

    fetch_unit #(.IW(IW), .DW(DW), .START_ADDR(0), .CW(CW)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .Stall(Stall),
        .BranchTaken(BranchTaken), .BranchAbs(BranchAbs),
        .BranchTarget(BranchTarget), .Halt(Halt),
        .InstAddress(InstAddress), .InstIn(InstIn), .InstReg(InstReg),
        .InstPC(InstPC), .InstValid(InstValid), .Done(Done),
        .CycleCount(CycleCount)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // 0 = idle, 1 = running, 2 = halted
    int            m_state = 0;
    logic [IW-1:0] m_pc = '0;
    logic [IW-1:0] m_ipc = '0;
    logic [DW-1:0] m_ir = '0;
    logic          m_v = 1'b0;
    logic          m_done = 1'b0;
    logic [CW-1:0] m_cc = '0;
    logic [IW+DW-1:0] exp_q [$];

    // Model advances on the same edges the DUT does.
    always @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            m_state = 0; m_pc = '0; m_ipc = '0; m_ir = '0;
            m_v = 1'b0; m_done = 1'b0; m_cc = '0;
            exp_q.delete();
        end else if (m_state == 0) begin
            if (Start) begin m_state = 1; m_pc = '0; m_cc = '0; end
        end else if (m_state == 2) begin
            if (Start) begin m_state = 1; m_pc = '0; m_cc = '0; m_done = 1'b0; end
        end else begin
            if (m_cc != CC_MAX) m_cc = m_cc + 1'b1;
            if (Stall) begin
                // frozen
            end else if (Halt && m_v) begin
                m_state = 2; m_v = 1'b0; m_done = 1'b1;
            end else if (BranchTaken && m_v) begin
                m_pc = BranchAbs ? BranchTarget : IW'(m_ipc + BranchTarget);
                m_v = 1'b0;
            end else begin
                m_ir = rom[m_pc]; m_ipc = m_pc; m_v = 1'b1; m_pc = m_pc + 1'b1;
            end
            if (m_v) exp_q.push_back({m_ipc, m_ir});
        end
    end

    // ---------------- monitor ----------------
    logic [IW+DW-1:0] e;
    always @(posedge CLK) begin
        #1;
        chk("inst_address", InstAddress, m_pc);
        chk("inst_valid", InstValid, m_v);
        chk("done", Done, m_done);
        chk("cycle_count", CycleCount, m_cc);
        if (InstValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL word: valid word pc=%0d with nothing expected", InstPC);
            end else begin
                e = exp_q.pop_front();
                chk("inst_pc", InstPC, e[IW+DW-1:DW]);
                chk("inst_reg", InstReg, e[DW-1:0]);
            end
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_ipc(input int pc);
        int k = 0;
        while (!(m_v && m_ipc == IW'(pc)) && k < 64) begin step(); k++; end
        if (!(m_v && m_ipc == IW'(pc))) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_ipc: InstPC %0d never reached", pc);
        end
    endtask

    task automatic jump(input logic abs, input logic [IW-1:0] t);
        int k = 0;
        while (!m_v && k < 8) begin step(); k++; end
        BranchTaken = 1'b1; BranchAbs = abs; BranchTarget = t;
        step();
        BranchTaken = 1'b0; BranchAbs = 1'b0; BranchTarget = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, InstAddress, 0);
        chk({tag, "_reg"}, InstReg, 0);
        chk({tag, "_pc"}, InstPC, 0);
        chk({tag, "_valid"}, InstValid, 0);
        chk({tag, "_done"}, Done, 0);
        chk({tag, "_cc"}, CycleCount, 0);
    endtask

    logic [CW-1:0] c0;

    initial begin
        for (int i = 0; i < (1 << IW); i++) rom[i] = DW'($urandom);

        repeat (2) step();
        chk_reset_vals("reset");
        Reset_n = 1'b1;

        // IDLE ignores everything but Start
        Stall = 1'b1; BranchTaken = 1'b1; Halt = 1'b1; BranchAbs = 1'b1; BranchTarget = 10'd77;
        repeat (2) step();
        Stall = 1'b0; BranchTaken = 1'b0; Halt = 1'b0; BranchAbs = 1'b0; BranchTarget = '0;
        chk("idle_valid", InstValid, 0);
        chk("idle_addr", InstAddress, 0);

        // Start and sequential fetch
        Start = 1'b1; step(); Start = 1'b0;
        chk("start_addr", InstAddress, 0);
        chk("start_valid", InstValid, 0);
        step();
        chk("first_pc", InstPC, 0);
        chk("first_reg", InstReg, rom[0]);
        chk("first_valid", InstValid, 1);
        chk("first_addr", InstAddress, 1);

        // Stall for three cycles at InstPC=2
        wait_ipc(2);
        c0 = CycleCount;
        Stall = 1'b1; repeat (3) step(); Stall = 1'b0;
        chk("stall_addr", InstAddress, 3);
        chk("stall_pc", InstPC, 2);
        chk("stall_reg", InstReg, rom[2]);
        chk("stall_valid", InstValid, 1);
        chk("stall_cc", CycleCount, c0 + 3);
        step();
        chk("unstall_pc", InstPC, 3);

        // Relative branch -2 from InstPC=5
        wait_ipc(5);
        jump(1'b0, 10'h3FE);
        chk("rel_bubble", InstValid, 0);
        chk("rel_addr", InstAddress, 3);
        step();
        chk("rel_next_pc", InstPC, 3);
        chk("rel_next_valid", InstValid, 1);

        // Absolute branch to 20
        jump(1'b1, 10'd20);
        step();
        chk("abs_next_pc", InstPC, 20);

        // Sequential PC wrap 1023 -> 0
        jump(1'b1, 10'd1022);
        wait_ipc(1022);
        chk("wrap_addr_hi", InstAddress, 1023);
        step();
        chk("wrap_addr_lo", InstAddress, 0);
        step();
        chk("wrap_pc0", InstPC, 0);

        // Relative +3 from InstPC=1022 lands on 1
        jump(1'b1, 10'd1020);
        wait_ipc(1022);
        jump(1'b0, 10'd3);
        chk("relwrap_addr", InstAddress, 1);
        step();
        chk("relwrap_pc", InstPC, 1);

        // Halt and branch together at InstPC=7: halt wins
        jump(1'b1, 10'd5);
        wait_ipc(7);
        Halt = 1'b1; BranchTaken = 1'b1; BranchAbs = 1'b1; BranchTarget = 10'd100;
        step();
        Halt = 1'b0; BranchTaken = 1'b0; BranchAbs = 1'b0; BranchTarget = '0;
        chk("halt_done", Done, 1);
        chk("halt_valid", InstValid, 0);
        chk("halt_addr", InstAddress, 8);
        c0 = CycleCount;
        repeat (3) step();
        chk("halt_addr_held", InstAddress, 8);
        chk("halt_cc_held", CycleCount, c0);
        Start = 1'b1; step(); Start = 1'b0;
        chk("restart_done", Done, 0);
        chk("restart_addr", InstAddress, 0);
        chk("restart_cc", CycleCount, 0);

        // Async reset between edges at InstPC=9
        wait_ipc(9);
        #1 Reset_n = 1'b0;
        #1 chk_reset_vals("async");
        step();
        Reset_n = 1'b1;
        Stall = 1'b1; BranchTaken = 1'b1; Halt = 1'b1;
        repeat (3) step();
        Stall = 1'b0; BranchTaken = 1'b0; Halt = 1'b0;
        chk("post_reset_valid", InstValid, 0);
        chk("post_reset_addr", InstAddress, 0);

        // Randomized phase
        Start = 1'b1; step(); Start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            Stall        = ($urandom_range(0, 4) == 0);
            BranchTaken  = ($urandom_range(0, 5) == 0);
            BranchAbs    = $urandom_range(0, 1) == 1;
            BranchTarget = IW'($urandom);
            Halt         = ($urandom_range(0, 99) == 0);
            Start        = ($urandom_range(0, 7) == 0);
            step();
            if ($urandom_range(0, 699) == 0) begin
                #1 Reset_n = 1'b0;
                #2 Reset_n = 1'b1;
            end
        end
        Stall = 1'b0; BranchTaken = 1'b0; Halt = 1'b0; Start = 1'b0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that drives the address into the 9-bit instruction ROM and registers the returned word for the decoder.
- Owns the program counter: sequential advance, absolute/relative branch redirect, stall hold, halt and restart.
- Sits between the control/decode stage (consumer of InstReg, source of Stall/Branch/Halt) and the combinational instruction ROM.

Parameters:
- IW, 10, PC / ROM address width
- DW, 9, instruction word width
- START_ADDR, 0, PC value loaded on reset and on Start
- CW, 16, cycle counter width

Ports:
- CLK  in  1  clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- Start  in  1  begin execution from START_ADDR (IDLE or HALTED only)
- Stall  in  1  freeze fetch stage this cycle
- BranchTaken  in  1  redirect for the instruction currently in InstReg
- BranchAbs  in  1  1 = absolute target, 0 = PC-relative
- BranchTarget  in  IW  absolute target, or two's-complement offset when relative
- Halt  in  1  instruction in InstReg is a halt
- InstAddress  out  IW  ROM address (the PC)
- InstIn  in  DW  ROM data, combinational from InstAddress
- InstReg  out  DW  registered instruction to decoder
- InstPC  out  IW  address InstReg was fetched from
- InstValid  out  1  InstReg holds a live instruction
- Done  out  1  program halted
- CycleCount  out  CW  cycles spent in RUN

Behaviour:
- Reset (async, Reset_n=0): state IDLE, InstAddress=START_ADDR, InstReg=0, InstPC=0, InstValid=0, Done=0, CycleCount=0. Takes effect immediately, including mid-RUN. Outputs are held while Reset_n=0.
- States: IDLE, RUN, HALTED. All updates occur on the rising edge of CLK.
- IDLE:
  - InstValid=0.
  - Start=1 -> RUN, PC=START_ADDR, CycleCount=0.
  - Stall, Branch and Halt are ignored.
- RUN: CycleCount increments every cycle and saturates at 2**CW-1. Priority order: Stall > Halt > BranchTaken > sequential.
  - Stall=1: PC, InstReg, InstPC, InstValid held. Branch and Halt are not sampled; the decoder holds them until Stall drops.
  - Halt=1 with InstValid=1 -> HALTED: InstValid<=0, Done<=1, PC frozen.
  - BranchTaken=1 with InstValid=1:
    - PC<=target.
    - InstValid<=0, squashing the wrong-path word fetched this cycle. Penalty is exactly one bubble.
    - Absolute target = BranchTarget.
    - Relative target = (InstPC + BranchTarget) mod 2**IW, with BranchTarget signed.
  - Otherwise: InstReg<=InstIn, InstPC<=PC, InstValid<=1, PC<=(PC+1) mod 2**IW. The PC wraps from 2**IW-1 to 0.
  - BranchTaken or Halt with InstValid=0 is ignored.
  - Start in RUN is ignored.
- Fetch latency: the word at address A appears on InstReg one cycle after InstAddress=A.
- HALTED:
  - Done=1, InstValid=0, PC and CycleCount held.
  - Start=1 -> RUN, PC=START_ADDR, CycleCount=0, Done<=0.
- Simultaneous events in RUN:
  - Halt and BranchTaken together -> Halt wins.
  - Stall together with either -> Stall wins, and nothing is sampled.

Test Plan:
- Reset then Start, ROM words 0..4 sequential, no Stall -> InstAddress 0,1,2,3 on consecutive cycles. InstReg equals rom[0] with InstPC=0 and InstValid=1 one cycle after Start is accepted. Thereafter one new word per cycle.
- Stall high for 3 cycles while InstPC=2 -> InstAddress stays 3, InstReg/InstPC stay rom[2]/2, InstValid stays 1, CycleCount still +3. Release -> InstPC 3 next cycle.
- Branch redirect:
  - Relative: BranchTaken, BranchAbs=0, offset=-2 (10'h3FE) at InstPC=5 -> InstValid=0 for one cycle, InstAddress=3, next valid InstPC=3.
  - Absolute: BranchAbs=1, BranchTarget=20 -> next valid InstPC=20.
- PC=1023 sequential -> InstAddress wraps to 0. Relative offset +3 from InstPC=1022 -> target 1.
- Halt and BranchTaken together at InstPC=7 -> Done=1, InstValid=0, PC frozen, CycleCount frozen. Start -> Done=0, InstAddress=0, CycleCount=0.
- Reset_n pulled low mid-RUN at InstPC=9, between clock edges -> all outputs return to reset values immediately and state returns to IDLE. Stall, Branch and Halt are then ignored until Start.
